execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/execute_muldiv.sv | 242 ++++++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// RV32M multiply/divide execute stage: radix-2 iterative divide, single-cycle or shift-add multiply.
// Latency: divide XLEN+1 busy cycles (zero divisor / MIN÷-1: 1 cycle), multiply 0 or XLEN+1; result registered on the next edge.
// Backpressure: md_busy stalls upstream combinationally; keep freezes all state, nop bubbles the output or flushes an operation.
module execute_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_ITER = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            keep,
  input  logic            nop,
  input  logic            is_md_pype1,
  input  logic [2:0]      md_op_pype1,
  input  logic [XLEN-1:0] rs1_pype1,
  input  logic [XLEN-1:0] rs2_pype1,
  input  logic [4:0]      WReg_pype1,
  output logic            md_busy,
  output logic [XLEN-1:0] md_result_pype2,
  output logic            md_valid_pype2,
  output logic [4:0]      WReg_pype2
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [5:0]      LAST_CNT = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  // FSM, counter and latched instruction context
  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        wreg_q, wreg_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  // hi = partial remainder / product high half, lo = quotient / multiplier then product low half
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  // registered EX/WB outputs
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;
  logic [4:0]        wreg_out_q, wreg_out_d;

  // operand decode
  logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic              div_zero, div_ovf, fast_path, iter_op;
  logic [XLEN-1:0]   a_mag, b_mag;

  // datapath intermediates
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mul_fast_res;
  logic [XLEN:0]     div_shift, div_diff, mul_sum;
  logic [2*XLEN-1:0] prod_mag, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, done_res;

  // Decode signedness, operand magnitudes and the divide special cases
  always_comb begin
    is_div = md_op_pype1[2];
    if (is_div) begin
      a_sgn = ~md_op_pype1[0];
      b_sgn = ~md_op_pype1[0];
    end else begin
      a_sgn = (md_op_pype1[1:0] != 2'b11);
      b_sgn = ~md_op_pype1[1];
    end
    a_neg     = a_sgn & rs1_pype1[XLEN-1];
    b_neg     = b_sgn & rs2_pype1[XLEN-1];
    a_mag     = a_neg ? (~rs1_pype1 + 1'b1) : rs1_pype1;
    b_mag     = b_neg ? (~rs2_pype1 + 1'b1) : rs2_pype1;
    div_zero  = (rs2_pype1 == '0);
    div_ovf   = ~md_op_pype1[0] & (rs1_pype1 == MIN_VAL) & (rs2_pype1 == '1);
    fast_path = is_div & (div_zero | div_ovf);
    iter_op   = is_div | (MUL_ITER != 0);
  end

  // Single-cycle multiply: sign-extend to 2*XLEN so one modular product serves all variants
  always_comb begin
    mul_a_ext    = {{XLEN{a_neg}}, rs1_pype1};
    mul_b_ext    = {{XLEN{b_neg}}, rs2_pype1};
    mul_prod     = mul_a_ext * mul_b_ext;
    mul_fast_res = (md_op_pype1[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // One restoring-divide trial subtraction and one shift-add partial sum per cycle
  always_comb begin
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  end

  // Sign fix-up of the unsigned magnitudes and result selection by op
  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod_fix = quo_neg_q ? (~prod_mag + 1'b1) : prod_mag;
    quo_fix  = quo_neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = rem_neg_q ? (~hi_q + 1'b1) : hi_q;
    case (op_q)
      3'b000:                 done_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: done_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         done_res = quo_fix;
      default:                done_res = rem_fix;
    endcase
  end

  // Next-state logic: keep holds everything, nop flushes, otherwise step the FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    wreg_d     = wreg_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    result_d   = result_q;
    valid_d    = valid_q;
    wreg_out_d = wreg_out_q;

    if (keep) begin
      // freeze
    end else if (nop) begin
      state_d    = IDLE;
      cnt_d      = '0;
      result_d   = '0;
      valid_d    = 1'b0;
      wreg_out_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          result_d   = '0;
          valid_d    = 1'b0;
          wreg_out_d = '0;
          cnt_d      = '0;
          if (is_md_pype1) begin
            if (iter_op) begin
              op_d   = md_op_pype1;
              wreg_d = WReg_pype1;
              if (fast_path) begin
                // results are fixed: quotient in lo, remainder in hi, no sign fix-up
                hi_d      = div_zero ? rs1_pype1 : '0;
                lo_d      = div_zero ? '1 : MIN_VAL;
                opb_d     = '0;
                quo_neg_d = 1'b0;
                rem_neg_d = 1'b0;
                state_d   = DONE;
              end else if (is_div) begin
                hi_d      = '0;
                lo_d      = a_mag;
                opb_d     = b_mag;
                quo_neg_d = a_neg ^ b_neg;
                rem_neg_d = a_neg;
                state_d   = CALC;
              end else begin
                hi_d      = '0;
                lo_d      = b_mag;
                opb_d     = a_mag;
                quo_neg_d = a_neg ^ b_neg;
                rem_neg_d = 1'b0;
                state_d   = CALC;
              end
            end else begin
              result_d   = mul_fast_res;
              valid_d    = 1'b1;
              wreg_out_d = WReg_pype1;
            end
          end
        end
        CALC: begin
          result_d   = '0;
          valid_d    = 1'b0;
          wreg_out_d = '0;
          if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
              hi_d = div_diff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = div_shift[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
        DONE: begin
          // return to IDLE unconditionally so the still-presented instruction is not restarted
          result_d   = done_res;
          valid_d    = 1'b1;
          wreg_out_d = wreg_q;
          cnt_d      = '0;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      wreg_q     <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      wreg_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      wreg_q     <= wreg_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      wreg_out_q <= wreg_out_d;
    end
  end

  // Stall while an iterative op starts or runs; low in DONE so upstream advances on the capture edge
  assign md_busy = rst & (((state_q == IDLE) & is_md_pype1 & iter_op & ~nop) | (state_q == CALC));

  assign md_result_pype2 = result_q;
  assign md_valid_pype2  = valid_q;
  assign WReg_pype2      = wreg_out_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: two instances (single-cycle and iterative multiply) with private inputs.
// Each operation is presented until md_busy drops; the next edge must deliver the modelled result.
// Also exercises keep, nop flush, non-MD bubbles and asynchronous reset.
module tb_execute_muldiv;

  localparam logic [31:0] MIN = 32'h8000_0000;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        keep_i [2];
  logic        nop_i  [2];
  logic        md_i   [2];
  logic [2:0]  op_i   [2];
  logic [31:0] a_i    [2];
  logic [31:0] b_i    [2];
  logic [4:0]  wr_i   [2];
  logic        busy_o [2];
  logic        vld_o  [2];
  logic [31:0] res_o  [2];
  logic [4:0]  wr_o   [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .MUL_ITER(0)) u_dut0 (
    .clk(clk), .rst(rst), .keep(keep_i[0]), .nop(nop_i[0]), .is_md_pype1(md_i[0]),
    .md_op_pype1(op_i[0]), .rs1_pype1(a_i[0]), .rs2_pype1(b_i[0]), .WReg_pype1(wr_i[0]),
    .md_busy(busy_o[0]), .md_result_pype2(res_o[0]), .md_valid_pype2(vld_o[0]), .WReg_pype2(wr_o[0])
  );

  execute_muldiv #(.XLEN(32), .MUL_ITER(1)) u_dut1 (
    .clk(clk), .rst(rst), .keep(keep_i[1]), .nop(nop_i[1]), .is_md_pype1(md_i[1]),
    .md_op_pype1(op_i[1]), .rs1_pype1(a_i[1]), .rs2_pype1(b_i[1]), .WReg_pype1(wr_i[1]),
    .md_busy(busy_o[1]), .md_result_pype2(res_o[1]), .md_valid_pype2(vld_o[1]), .WReg_pype2(wr_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural RV32M result from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin pu = ua * ub; return pu[63:32]; end
      OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        p = sa / sb;
        return p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        pu = ua / ub;
        return pu[31:0];
      end
      OP_REM: begin
        if (b == 32'h0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        pu = ua % ub;
        return pu[31:0];
      end
    endcase
  endfunction

  // Expected number of cycles md_busy is high for one operation
  function automatic int exp_busy(input int sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 32'h0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
    return (sel == 1) ? 33 : 0;
  endfunction

  task automatic idle_inputs();
    for (int s = 0; s < 2; s++) begin
      keep_i[s] = 1'b0; nop_i[s] = 1'b0; md_i[s] = 1'b0; op_i[s] = 3'b0;
      a_i[s] = 32'h0; b_i[s] = 32'h0; wr_i[s] = 5'h0;
    end
  endtask

  // Present one instruction, hold it while md_busy, then check the captured result
  task automatic run_op(input string tag, input int sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wr, input int keep_at, input int keep_len);
    int          busy_cnt;
    bit          early;
    logic [31:0] exp_r;
    int          exp_b;
    busy_cnt = 0;
    early    = 1'b0;
    exp_r    = model(op, a, b);
    exp_b    = exp_busy(sel, op, a, b) + keep_len;
    @(negedge clk);
    md_i[sel] = 1'b1; op_i[sel] = op; a_i[sel] = a; b_i[sel] = b; wr_i[sel] = wr;
    #1;
    while (busy_o[sel] === 1'b1 && busy_cnt < 300) begin
      busy_cnt++;
      keep_i[sel] = (keep_len > 0) && (busy_cnt > keep_at) && (busy_cnt <= keep_at + keep_len);
      @(posedge clk); #1;
      if (vld_o[sel] !== 1'b0) early = 1'b1;
    end
    keep_i[sel] = 1'b0;
    @(posedge clk); #1;
    chk({tag, " busy cycles"}, busy_cnt, exp_b);
    chk({tag, " valid while busy"}, 32'(early), 32'h0);
    chk({tag, " valid"}, 32'(vld_o[sel]), 32'h1);
    chk({tag, " result"}, res_o[sel], exp_r);
    chk({tag, " wreg"}, 32'(wr_o[sel]), 32'(wr));
    md_i[sel] = 1'b0; op_i[sel] = 3'b0; a_i[sel] = 32'h0; b_i[sel] = 32'h0; wr_i[sel] = 5'h0;
  endtask

  typedef struct {
    int          sel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit late;

    vecs[0]  = '{1, OP_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2};
    vecs[1]  = '{1, OP_REM,    32'd100,       32'hFFFF_FFF9, 32'h0000_0002};
    vecs[2]  = '{1, OP_DIVU,   32'h0000_1234, 32'h0,         32'hFFFF_FFFF};
    vecs[3]  = '{1, OP_REMU,   32'h0000_1234, 32'h0,         32'h0000_1234};
    vecs[4]  = '{1, OP_DIV,    MIN,           32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5]  = '{1, OP_REM,    MIN,           32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{0, OP_MULH,   MIN,           MIN,           32'h4000_0000};
    vecs[7]  = '{0, OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    vecs[8]  = '{0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[9]  = '{1, OP_MULH,   MIN,           MIN,           32'h4000_0000};
    vecs[10] = '{1, OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    vecs[11] = '{1, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[12] = '{1, OP_MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB};
    vecs[13] = '{1, OP_DIV,    32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2};
    vecs[14] = '{1, OP_REM,    32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE};
    vecs[15] = '{1, OP_DIVU,   32'hFFFF_FFFF, 32'd3,         32'h5555_5555};
    vecs[16] = '{0, OP_DIV,    32'd7,         32'h0,         32'hFFFF_FFFF};
    vecs[17] = '{0, OP_REM,    32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB};
    vecs[18] = '{1, OP_REMU,   32'd100,       32'd7,         32'h0000_0002};
    vecs[19] = '{0, OP_MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB};

    // Reset with a divide presented: busy and all outputs must be 0
    idle_inputs();
    rst = 1'b0;
    md_i[0] = 1'b1; op_i[0] = OP_DIV; a_i[0] = 32'd9; b_i[0] = 32'd5; wr_i[0] = 5'd3;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset busy dut%0d", s), 32'(busy_o[s]), 32'h0);
      chk($sformatf("reset valid dut%0d", s), 32'(vld_o[s]), 32'h0);
      chk($sformatf("reset result dut%0d", s), res_o[s], 32'h0);
      chk($sformatf("reset wreg dut%0d", s), 32'(wr_o[s]), 32'h0);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors: model pinned to hand values, DUT checked against the model
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("v%0d model", i), model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op($sformatf("v%0d", i), vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 0, 0);
    end

    // nop with an MD instruction in IDLE: bubble, no stall
    @(negedge clk);
    md_i[0] = 1'b1; op_i[0] = OP_MUL; a_i[0] = 32'd3; b_i[0] = 32'd4; wr_i[0] = 5'd6; nop_i[0] = 1'b1;
    #1;
    chk("idle nop busy", 32'(busy_o[0]), 32'h0);
    @(posedge clk); #1;
    chk("idle nop valid", 32'(vld_o[0]), 32'h0);
    chk("idle nop wreg", 32'(wr_o[0]), 32'h0);
    idle_inputs();

    // Non-MD instruction in IDLE after a real result: outputs cleared
    run_op("pre-nonmd", 0, OP_MUL, 32'd6, 32'd7, 5'd11, 0, 0);
    @(negedge clk);
    wr_i[0] = 5'd5; a_i[0] = 32'd1; b_i[0] = 32'd1;
    @(posedge clk); #1;
    chk("nonmd valid", 32'(vld_o[0]), 32'h0);
    chk("nonmd result", res_o[0], 32'h0);
    chk("nonmd wreg", 32'(wr_o[0]), 32'h0);
    idle_inputs();

    // keep for 5 cycles mid-CALC delays completion by exactly 5 cycles
    run_op("keep", 1, OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd12, 10, 5);

    // nop at cnt=10 of a divide aborts to IDLE
    @(negedge clk);
    md_i[1] = 1'b1; op_i[1] = OP_DIV; a_i[1] = 32'd100; b_i[1] = 32'hFFFF_FFF9; wr_i[1] = 5'd9;
    repeat (11) @(posedge clk);
    #1;
    chk("flush busy before", 32'(busy_o[1]), 32'h1);
    nop_i[1] = 1'b1;
    @(posedge clk); #1;
    nop_i[1] = 1'b0; md_i[1] = 1'b0;
    #1;
    chk("flush busy after", 32'(busy_o[1]), 32'h0);
    chk("flush valid", 32'(vld_o[1]), 32'h0);
    chk("flush wreg", 32'(wr_o[1]), 32'h0);
    late = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (vld_o[1] !== 1'b0) late = 1'b1;
    end
    chk("flush no result", 32'(late), 32'h0);
    idle_inputs();

    // Reset off the clock edge clears a held result immediately
    run_op("pre-reset", 1, OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd9, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst valid", 32'(vld_o[1]), 32'h0);
    chk("async rst result", res_o[1], 32'h0);
    chk("async rst wreg", 32'(wr_o[1]), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset pulse mid-CALC discards the operation
    @(negedge clk);
    md_i[1] = 1'b1; op_i[1] = OP_DIV; a_i[1] = 32'd100; b_i[1] = 32'hFFFF_FFF9; wr_i[1] = 5'd9;
    repeat (10) @(posedge clk);
    #2;
    md_i[1] = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy_o[1]), 32'h0);
    chk("mid rst valid", 32'(vld_o[1]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    late = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (vld_o[1] !== 1'b0 || busy_o[1] !== 1'b0) late = 1'b1;
    end
    chk("mid rst no result", 32'(late), 32'h0);
    idle_inputs();

    // Normal operation resumes after reset
    run_op("post-reset", 1, OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd21, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
